// File: rtl/sd_read_arbiter.sv
// sd_read_arbiter: round-robin arbiter that shares one sd_card_reader between
// NUM_REQ sector-read requesters. It latches the winner's sector/count, pulses
// the reader's start, supervises the transfer with an idle timeout, and routes
// bytes plus a final done/error pulse back to the granted requester only.
module sd_read_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 10_000_000
) (
  input  logic                       clk100mhz,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [32*NUM_REQ-1:0]      req_sector,
  input  logic [8*NUM_REQ-1:0]       req_count,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [7:0]                 rsp_data,
  output logic [NUM_REQ-1:0]         rsp_valid,
  output logic [NUM_REQ-1:0]         rsp_done,
  output logic [NUM_REQ-1:0]         rsp_error,
  output logic                       rd_start,
  output logic [31:0]                rd_sector,
  output logic [7:0]                 rd_count,
  input  logic [7:0]                 rd_data,
  input  logic                       rd_valid,
  input  logic                       rd_busy,
  input  logic                       rd_error,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       active
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, XFER, DRAIN, DONE} state_t;

  state_t              state;
  logic [GW-1:0]       last_grant;
  logic                err_flag;
  logic [16:0]         byte_cnt;
  logic [TW-1:0]       tmo_cnt;

  logic                pick_found;
  logic [GW-1:0]       pick_idx;
  logic [31:0]         pick_sector;
  logic [7:0]          pick_count;
  logic [NUM_REQ-1:0]  grant_oh;
  logic [16:0]         byte_cnt_nxt;
  logic [16:0]         byte_exp;
  logic                tmo_hit;

  // Requester examined k-th when the search starts just after base.
  function automatic int rr_index(input logic [GW-1:0] base, input int k);
    return (int'(base) + 1 + k) % NUM_REQ;
  endfunction

  assign grant_oh     = ONE_HOT0 << grant_id;
  assign byte_exp     = {rd_count, 9'd0};
  // Saturate so a runaway reader can never wrap back onto the expected total.
  assign byte_cnt_nxt = (rd_valid && (byte_cnt != '1)) ? byte_cnt + 17'd1 : byte_cnt;
  assign tmo_hit      = (tmo_cnt == TW'(TIMEOUT_CYCLES));

  // Round-robin pick: first valid requester searching upward from last_grant+1.
  always_comb begin
    pick_found  = 1'b0;
    pick_idx    = '0;
    pick_sector = '0;
    pick_count  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!pick_found && req_valid[rr_index(last_grant, k)]) begin
        pick_found  = 1'b1;
        pick_idx    = GW'(rr_index(last_grant, k));
        pick_sector = req_sector[rr_index(last_grant, k)*32 +: 32];
        pick_count  = req_count[rr_index(last_grant, k)*8 +: 8];
      end
    end
  end

  // Transfer FSM with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk100mhz or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GW'(NUM_REQ - 1);
      err_flag   <= 1'b0;
      byte_cnt   <= '0;
      tmo_cnt    <= '0;
      req_ready  <= '0;
      rsp_data   <= '0;
      rsp_valid  <= '0;
      rsp_done   <= '0;
      rsp_error  <= '0;
      rd_start   <= 1'b0;
      rd_sector  <= '0;
      rd_count   <= '0;
      grant_id   <= '0;
      active     <= 1'b0;
    end else begin
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_done  <= '0;
      rsp_error <= '0;
      rd_start  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found && !rd_busy) begin
            grant_id  <= pick_idx;
            rd_sector <= pick_sector;
            rd_count  <= pick_count;
            req_ready <= ONE_HOT0 << pick_idx;
            active    <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          // A zero-block request never touches the reader; DRAIN completes it
          // as soon as the (already idle) reader reports not busy.
          if (rd_count == 8'd0) begin
            state <= DRAIN;
          end else begin
            rd_start <= 1'b1;
            tmo_cnt  <= '0;
            state    <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          if (rd_busy) begin
            tmo_cnt <= '0;
            state   <= XFER;
          end else if (tmo_hit) begin
            err_flag  <= 1'b1;
            rsp_error <= grant_oh;
            state     <= DONE;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        XFER: begin
          byte_cnt <= byte_cnt_nxt;
          if (rd_valid) begin
            rsp_data  <= rd_data;
            rsp_valid <= grant_oh;
          end
          // Reader error outranks a simultaneous end of busy.
          if (rd_error) begin
            err_flag <= 1'b1;
            if (!rd_busy) begin
              rsp_error <= grant_oh;
              state     <= DONE;
            end else begin
              state <= DRAIN;
            end
          end else if (!rd_busy) begin
            // The count check includes a byte arriving in this same cycle.
            if (err_flag || (byte_cnt_nxt != byte_exp)) begin
              err_flag  <= 1'b1;
              rsp_error <= grant_oh;
            end else begin
              rsp_done <= grant_oh;
            end
            state <= DONE;
          end else if (rd_valid) begin
            tmo_cnt <= '0;
          end else if (tmo_hit) begin
            err_flag <= 1'b1;
            state    <= DRAIN;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        DRAIN: begin
          byte_cnt <= byte_cnt_nxt;
          if (!rd_busy) begin
            if (err_flag) rsp_error <= grant_oh;
            else          rsp_done  <= grant_oh;
            state <= DONE;
          end
        end
        DONE: begin
          last_grant <= grant_id;
          err_flag   <= 1'b0;
          byte_cnt   <= '0;
          tmo_cnt    <= '0;
          active     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Testbench for sd_read_arbiter: directed requests and a scripted reader;
// expected events are queued at issue time and a forked monitor checks them.
module tb_sd_read_arbiter;

  localparam int NR  = 4;
  localparam int TMO = 100;
  localparam int K_READY = 0, K_START = 1, K_BYTE = 2, K_DONE = 3, K_ERR = 4;

  typedef struct {
    int          kind;
    logic [3:0]  vec;
    logic [31:0] sec;
    logic [7:0]  cnt;
    int          gap;
  } exp_t;

  logic          clk100mhz = 1'b0;
  logic          rst = 1'b0;
  logic [3:0]    req_valid = '0;
  logic [127:0]  req_sector = '0;
  logic [31:0]   req_count = '0;
  logic [3:0]    req_ready;
  logic [7:0]    rsp_data;
  logic [3:0]    rsp_valid, rsp_done, rsp_error;
  logic          rd_start;
  logic [31:0]   rd_sector;
  logic [7:0]    rd_count;
  logic [7:0]    rd_data = '0;
  logic          rd_valid = 1'b0, rd_busy = 1'b0, rd_error = 1'b0;
  logic [1:0]    grant_id;
  logic          active;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   last_cyc = 0;

  sd_read_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk100mhz(clk100mhz), .rst(rst),
    .req_valid(req_valid), .req_sector(req_sector), .req_count(req_count),
    .req_ready(req_ready), .rsp_data(rsp_data), .rsp_valid(rsp_valid),
    .rsp_done(rsp_done), .rsp_error(rsp_error), .rd_start(rd_start),
    .rd_sector(rd_sector), .rd_count(rd_count), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_busy(rd_busy), .rd_error(rd_error),
    .grant_id(grant_id), .active(active)
  );

  always #5 clk100mhz = ~clk100mhz;
  always @(posedge clk100mhz) cyc <= cyc + 1;

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] pat(input int seq, input int b);
    return 8'((seq * 53 + b * 7 + (b >> 8)) & 255);
  endfunction

  function automatic string kname(input int k);
    case (k)
      K_READY: return "req_ready";
      K_START: return "rd_start";
      K_BYTE:  return "rsp_byte";
      K_DONE:  return "rsp_done";
      default: return "rsp_error";
    endcase
  endfunction

  task automatic push(input int kind, input logic [3:0] vec, input logic [31:0] sec,
                      input logic [7:0] cnt, input int gap);
    exp_t e;
    e.kind = kind; e.vec = vec; e.sec = sec; e.cnt = cnt; e.gap = gap;
    sb.push_back(e);
  endtask

  // Expected READY/START, n forwarded bytes, then a done or error pulse.
  task automatic expect_xfer(input int r, input logic [31:0] sec, input logic [7:0] cnt,
                             input int nbytes, input int seq, input int end_kind);
    push(K_READY, 4'(1 << r), sec, cnt, -1);
    push(K_START, 4'b0, sec, cnt, 1);
    for (int b = 0; b < nbytes; b++) push(K_BYTE, 4'(1 << r), {24'h0, pat(seq, b)}, 8'h0, -1);
    push(end_kind, 4'(1 << r), 32'h0, 8'h0, -1);
  endtask

  task automatic observe(input int kind, input logic [3:0] vec, input logic [31:0] sec,
                         input logic [7:0] cnt);
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected %s: got vec=%b sec=%h cnt=%h at cycle %0d, required no event",
               kname(kind), vec, sec, cnt, cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.vec != vec || e.sec != sec || e.cnt != cnt ||
          (e.gap >= 0 && (cyc - last_cyc) != e.gap)) begin
        n_bad++;
        $display("FAIL %s: got %s vec=%b sec=%h cnt=%h gap=%0d, required %s vec=%b sec=%h cnt=%h gap=%0d",
                 kname(e.kind), kname(kind), vec, sec, cnt, cyc - last_cyc,
                 kname(e.kind), e.vec, e.sec, e.cnt, e.gap);
      end
    end
    last_cyc = cyc;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, " req_ready"}, 32'(req_ready), 0);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, " rsp_done"},  32'(rsp_done), 0);
    chk({tag, " rsp_error"}, 32'(rsp_error), 0);
    chk({tag, " rsp_data"},  32'(rsp_data), 0);
    chk({tag, " rd_start"},  32'(rd_start), 0);
    chk({tag, " rd_sector"}, rd_sector, 0);
    chk({tag, " rd_count"},  32'(rd_count), 0);
    chk({tag, " grant_id"},  32'(grant_id), 0);
    chk({tag, " active"},    32'(active), 0);
  endtask

  task automatic set_req(input int r, input logic [31:0] sec, input logic [7:0] cnt);
    req_sector[r*32 +: 32] = sec;
    req_count[r*8 +: 8]    = cnt;
    req_valid[r]           = 1'b1;
  endtask

  task automatic wait_ready(input int r);
    bit seen = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      @(negedge clk100mhz);
      if (req_ready[r]) seen = 1;
    end
    req_valid[r] = 1'b0;
    if (!seen) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_wait[%0d]: got no req_ready in 200 cycles, required a pulse", r);
    end
  endtask

  task automatic wait_start(output bit ok);
    ok = 0;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk100mhz);
      if (rd_start) ok = 1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL start_wait: got no rd_start in 50 cycles, required a pulse");
    end
  endtask

  // Reader model after rd_start: raise busy, stream bytes (idle gap every 13th),
  // optionally an error pulse followed by extra bytes, then drop busy.
  task automatic serve_body(input int nbytes, input int seq, input bit err,
                            input int extra, input bit fall_last);
    rd_busy = 1'b1;
    @(negedge clk100mhz);
    for (int b = 0; b < nbytes; b++) begin
      rd_valid = 1'b1;
      rd_data  = pat(seq, b);
      if (fall_last && b == nbytes - 1) rd_busy = 1'b0;
      @(negedge clk100mhz);
      rd_valid = 1'b0;
      if (b % 13 == 12) @(negedge clk100mhz);
    end
    if (err) begin
      rd_error = 1'b1;
      @(negedge clk100mhz);
      rd_error = 1'b0;
      for (int e = 0; e < extra; e++) begin
        rd_valid = 1'b1;
        rd_data  = 8'hEE;
        @(negedge clk100mhz);
      end
      rd_valid = 1'b0;
    end
    rd_busy = 1'b0;
    @(negedge clk100mhz);
  endtask

  task automatic wait_idle(input string name);
    bit idle = 0;
    for (int k = 0; k < 3000 && !idle; k++) begin
      @(negedge clk100mhz);
      if (sb.size() == 0 && !active) idle = 1;
    end
    if (!idle) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: got %0d expected events still pending, required 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    bit ok;
    // Monitor: compares every DUT output event against the scoreboard head.
    fork
      forever begin
        @(negedge clk100mhz);
        if (!rst) begin
          if (|req_ready) observe(K_READY, req_ready, rd_sector, rd_count);
          if (rd_start)   observe(K_START, 4'b0, rd_sector, rd_count);
          if (|rsp_valid) observe(K_BYTE, rsp_valid, {24'h0, rsp_data}, 8'h0);
          if (|rsp_done)  observe(K_DONE, rsp_done, 32'h0, 8'h0);
          if (|rsp_error) observe(K_ERR, rsp_error, 32'h0, 8'h0);
        end
      end
    join_none

    // Reset state
    #1 rst = 1'b1;
    repeat (3) @(negedge clk100mhz);
    chk_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk100mhz);
    chk("post-reset grant_id", 32'(grant_id), 0);
    chk("post-reset active", 32'(active), 0);

    // Round robin: all four held, three rounds of count=1
    for (int k = 0; k < 12; k++)
      expect_xfer(k % 4, 32'hA000_0000 | 32'(k % 4), 8'd1, 512, k, K_DONE);
    for (int r = 0; r < 4; r++) set_req(r, 32'hA000_0000 | 32'(r), 8'd1);
    for (int k = 0; k < 12; k++) begin
      wait_start(ok);
      if (k == 11) req_valid = '0;
      if (ok) serve_body(512, k, 1'b0, 0, k[0]);
    end
    req_valid = '0;
    wait_idle("round_robin");

    // Single request, last byte coincides with busy falling
    expect_xfer(1, 32'h0001_0000, 8'd1, 512, 20, K_DONE);
    set_req(1, 32'h0001_0000, 8'd1);
    wait_ready(1);
    wait_start(ok);
    if (ok) serve_body(512, 20, 1'b0, 0, 1'b1);
    wait_idle("single");

    // Reader never goes busy: error 101 cycles after rd_start, then a new accept
    push(K_READY, 4'b0001, 32'h0000_0500, 8'd1, -1);
    push(K_START, 4'b0000, 32'h0000_0500, 8'd1, 1);
    push(K_ERR,   4'b0001, 32'h0, 8'h0, TMO + 1);
    push(K_READY, 4'b0010, 32'h0000_0600, 8'd0, -1);
    push(K_DONE,  4'b0010, 32'h0, 8'h0, 2);
    set_req(0, 32'h0000_0500, 8'd1);
    wait_ready(0);
    wait_start(ok);
    set_req(1, 32'h0000_0600, 8'd0);
    wait_ready(1);
    wait_idle("timeout");

    // Reader error after 100 bytes, busy held 50 more cycles with bytes
    expect_xfer(2, 32'h0000_2000, 8'd1, 100, 30, K_ERR);
    set_req(2, 32'h0000_2000, 8'd1);
    wait_ready(2);
    wait_start(ok);
    if (ok) serve_body(100, 30, 1'b1, 50, 1'b0);
    wait_idle("rd_error");

    // Byte count mismatch: count=2 but 600 bytes delivered
    expect_xfer(3, 32'h0003_0000, 8'd2, 600, 40, K_ERR);
    set_req(3, 32'h0003_0000, 8'd2);
    wait_ready(3);
    wait_start(ok);
    if (ok) serve_body(600, 40, 1'b0, 0, 1'b0);
    wait_idle("short");

    // Zero-block request: done two cycles after ready, no rd_start
    push(K_READY, 4'b0001, 32'h0000_0777, 8'd0, -1);
    push(K_DONE,  4'b0001, 32'h0, 8'h0, 2);
    set_req(0, 32'h0000_0777, 8'd0);
    wait_ready(0);
    wait_idle("count0");

    // Reset during XFER of requester 1
    push(K_READY, 4'b0010, 32'h0000_9000, 8'd1, -1);
    push(K_START, 4'b0000, 32'h0000_9000, 8'd1, 1);
    for (int b = 0; b < 50; b++) push(K_BYTE, 4'b0010, {24'h0, pat(50, b)}, 8'h0, -1);
    set_req(1, 32'h0000_9000, 8'd1);
    wait_ready(1);
    wait_start(ok);
    rd_busy = 1'b1;
    @(negedge clk100mhz);
    for (int b = 0; b < 50; b++) begin
      rd_valid = 1'b1;
      rd_data  = pat(50, b);
      @(negedge clk100mhz);
      rd_valid = 1'b0;
      if (b % 13 == 12) @(negedge clk100mhz);
    end
    @(negedge clk100mhz);
    #1 rst = 1'b1;
    #1 chk_outputs_zero("async reset");
    chk("pending after reset", 32'(sb.size()), 0);
    sb.delete();
    rd_busy = 1'b0;
    repeat (3) @(negedge clk100mhz);
    rst = 1'b0;
    @(negedge clk100mhz);

    // After reset requester 0 wins a 0/2 tie
    push(K_READY, 4'b0001, 32'h0000_0100, 8'd0, -1);
    push(K_DONE,  4'b0001, 32'h0, 8'h0, 2);
    push(K_READY, 4'b0100, 32'h0000_0200, 8'd0, -1);
    push(K_DONE,  4'b0100, 32'h0, 8'h0, 2);
    set_req(0, 32'h0000_0100, 8'd0);
    set_req(2, 32'h0000_0200, 8'd0);
    wait_ready(0);
    wait_ready(2);
    wait_idle("reset_tie");

    repeat (5) @(negedge clk100mhz);
    chk("final pending events", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sd_read_arbiter.md
# sd_read_arbiter

Shares the single `sd_card_reader` instance between up to NUM_REQ independent sector-read requesters, such as a boot loader, a frame fetcher and a debug port. Round-robin arbitration picks one requester and latches its sector address and block count. The block drives the reader's start pulse and supervises the transfer with a timeout. It steers the byte stream and the completion or error status back to the granted requester only. It sits between the client logic and `sd_card_reader` inside `top`.

## Interface
Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 10_000_000, idle-cycle limit while waiting on the reader (100 ms at 100 MHz)

Ports:
- clk100mhz  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester read request; held until its req_ready
- req_sector  in  32*NUM_REQ  packed sector addresses, requester i at [32i+31:32i]
- req_count  in  8*NUM_REQ  packed block counts, requester i at [8i+7:8i]
- req_ready  out  NUM_REQ  one-hot, one-cycle accept pulse
- rsp_data  out  8  byte to the granted requester (broadcast, qualify with rsp_valid)
- rsp_valid  out  NUM_REQ  one-hot byte strobe
- rsp_done  out  NUM_REQ  one-hot, one-cycle successful-completion pulse
- rsp_error  out  NUM_REQ  one-hot, one-cycle failure pulse
- rd_start  out  1  to reader start_read, one-cycle pulse
- rd_sector  out  32  to reader sector_addr, stable from rd_start until the transfer ends
- rd_count  out  8  to reader block_count, same stability as rd_sector
- rd_data  in  8  reader data_out
- rd_valid  in  1  reader data_valid
- rd_busy  in  1  reader busy
- rd_error  in  1  reader error
- grant_id  out  $clog2(NUM_REQ)  index of the current/last granted requester
- active  out  1  high from accept until the done/error pulse, inclusive

## Operation
- States: IDLE, START, WAIT_BUSY, XFER, DRAIN, DONE.
- IDLE:
  - Entry requires rd_busy low.
  - If any req_valid is high, pick the first set bit searching upward from last_grant+1 (mod NUM_REQ).
  - Latch that requester's sector and count, set grant_id, pulse req_ready[grant], then go to START.
  - If the latched count is 0, skip the read and go straight to DONE with success.
- START: rd_start=1 for exactly one cycle, then go to WAIT_BUSY.
- WAIT_BUSY:
  - When rd_busy goes high, go to XFER.
  - If TIMEOUT_CYCLES elapse first, set err_flag and go to DONE.
- XFER:
  - Each rd_valid registers rd_data to rsp_data and pulses rsp_valid[grant].
  - The 17-bit byte counter increments on each rd_valid. Expected total is count*512; max 130560.
  - rd_error high sets err_flag and moves to DRAIN.
  - When rd_busy falls, go to DONE. Set err_flag if byte counter ≠ count*512.
  - The timeout counter restarts on every rd_valid. Expiry sets err_flag and moves to DRAIN.
- DRAIN:
  - Bytes are still counted but not forwarded (rsp_valid stays 0).
  - Wait for rd_busy low, then go to DONE.
- DONE:
  - Pulse rsp_done[grant] if err_flag is 0, otherwise rsp_error[grant].
  - last_grant←grant, clear err_flag and counters, then go to IDLE.
- Fairness: a requester that has just been served has the lowest priority on the next arbitration.
- Non-granted requesters see no strobes. A req_valid that drops before req_ready is simply not considered.

## Timing
- Reset:
  - All outputs are 0; grant_id=0; active=0.
  - State is IDLE; last_grant=NUM_REQ-1, so requester 0 wins the first tie.
  - Counters and err_flag are 0.
  - Reset mid-transfer aborts with no done/error pulse. The reader has its own reset.
- All outputs are registered.
- req_valid sampled high in IDLE at edge N gives req_ready at N+1 and rd_start at N+2.
- The rd_sector/rd_count values are valid from N+1.
- rd_valid at edge M gives rsp_valid/rsp_data at M+1.
- rd_busy low sampled at edge K in XFER/DRAIN gives the done/error pulse at K+1. active falls at K+2.
- Minimum gap between done pulse and the next req_ready is 1 cycle (DONE→IDLE→accept).
- rd_error and a falling rd_busy in the same cycle: the error wins and goes to DONE with rsp_error.
- rd_valid in the same cycle that rd_busy falls: the byte is forwarded and counted before the count check.

## Test plan
- Single request: requester 1, sector 0x00010000, count 1, with the reader model sending 512 bytes.
  - Required: req_ready[1] one cycle, then rd_start one cycle later with rd_sector=0x00010000, rd_count=1.
  - Required: 512 rsp_valid[1] pulses with matching data, then rsp_done[1].
- All four requesters held valid continuously, 3 rounds of count=1 each.
  - Required grant order: 0,1,2,3,0,1,2,3,0,1,2,3. No requester gets two grants in a row while others wait.
- Reader never raises rd_busy, with TIMEOUT_CYCLES=100.
  - Required: rsp_error[grant] exactly at accept+2+100 cycles; the next request is accepted afterwards.
- Reader asserts rd_error after 100 bytes, then holds busy for 50 more cycles while emitting bytes.
  - Required: exactly 100 rsp_valid pulses, then rsp_error only after rd_busy falls, with no rsp_done.
- Short transfer: count=2, the reader delivers 600 bytes and drops busy.
  - Required: rsp_error. Separately, count=0 gives rsp_done 2 cycles after req_ready with no rd_start.
- rst asserted during XFER.
  - Required: all outputs 0 asynchronously; after release, requester 0 wins a 0/2 tie.
